// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory port-0 arbiter: address/data
//   widths, arbiter state encodings and read-response owner codes.
package dmem_arb_pkg;

   localparam int HBIT_ADDR = 15;
   localparam int HBIT_DATA = 15;
   localparam int SIZE_ADDR = HBIT_ADDR + 1;
   localparam int SIZE_DATA = HBIT_DATA + 1;

   typedef enum logic [1:0] {
      S_CORE  = 2'd0,
      S_BURST = 2'd1,
      S_YIELD = 2'd2
   } arb_state_t;

   // Owner of an in-flight read.
   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DMA  = 1'b1;

endpackage

// File: rtl/dmem_arb.sv
// dmem_arb
//   Shares data-memory port 0 between the pipeline (MA/MO stages, "core")
//   and a DMA/loader requester. The core has priority; a starvation counter
//   force-grants the DMA after STARVE_MAX denied cycles, and a locked burst
//   gives the DMA up to BURST_MAX consecutive grants followed by one yield
//   cycle for the core. Read responses are steered back to the requester
//   that issued them, one cycle after the grant.
//
// Ports
//   iw_clk, iw_rst                 clock, async active-high reset
//   iw_core_req/we/addr/wdata      core access request
//   ow_core_gnt                    core access issued this cycle (comb)
//   ow_core_stall                  core requesting but not granted
//   ow_core_rvalid/rdata           core read response
//   iw_dma_req/we/addr/wdata/lock  DMA access request, lock = burst request
//   ow_dma_gnt/rvalid/rdata        DMA grant and read response
//   ow_mem_we/addr/wdata           memory port 0 command
//   iw_mem_rdata                   memory read data (one cycle after address)
//   ow_dbg_state                   current arbiter state
//
// Handshake: a requester holds req/we/addr/wdata stable until the cycle its
// gnt is 1; that cycle the access is issued. Keeping req high after a grant
// is a new access. rvalid is a one-cycle pulse with no back-pressure.
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 8
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic                 iw_core_req,
   input  logic                 iw_core_we,
   input  logic [HBIT_ADDR:0]   iw_core_addr,
   input  logic [HBIT_DATA:0]   iw_core_wdata,
   output logic                 ow_core_gnt,
   output logic                 ow_core_stall,
   output logic                 ow_core_rvalid,
   output logic [HBIT_DATA:0]   ow_core_rdata,
   input  logic                 iw_dma_req,
   input  logic                 iw_dma_we,
   input  logic [HBIT_ADDR:0]   iw_dma_addr,
   input  logic [HBIT_DATA:0]   iw_dma_wdata,
   input  logic                 iw_dma_lock,
   output logic                 ow_dma_gnt,
   output logic                 ow_dma_rvalid,
   output logic [HBIT_DATA:0]   ow_dma_rdata,
   output logic                 ow_mem_we,
   output logic [HBIT_ADDR:0]   ow_mem_addr,
   output logic [HBIT_DATA:0]   ow_mem_wdata,
   input  logic [HBIT_DATA:0]   iw_mem_rdata,
   output logic [1:0]           ow_dbg_state
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

   arb_state_t           r_state;
   logic [SW-1:0]        r_starve;
   logic [BW-1:0]        r_burst;
   logic                 r_rd_valid;
   logic                 r_rd_owner;
   logic [HBIT_ADDR:0]   r_addr;
   logic [HBIT_DATA:0]   r_wdata;

   logic                 w_core_gnt;
   logic                 w_dma_gnt;

   // Grant decision. Reset gates everything so no access leaks out while
   // iw_rst is high.
   always_comb begin
      w_core_gnt = 1'b0;
      w_dma_gnt  = 1'b0;
      if (!iw_rst) begin
         case (r_state)
            S_CORE: begin
               if (iw_dma_req && (r_starve == STARVE_LIM)) w_dma_gnt  = 1'b1;
               else if (iw_core_req)                       w_core_gnt = 1'b1;
               else if (iw_dma_req)                        w_dma_gnt  = 1'b1;
            end
            S_BURST: begin
               // Once the DMA drops req or lock the burst ends; only the
               // core may be served in that cycle.
               if (iw_dma_req && iw_dma_lock && (r_burst < BURST_LIM)) w_dma_gnt  = 1'b1;
               else if (iw_core_req)                                   w_core_gnt = 1'b1;
            end
            S_YIELD: begin
               if (iw_core_req)     w_core_gnt = 1'b1;
               else if (iw_dma_req) w_dma_gnt  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ow_core_gnt   = w_core_gnt;
   assign ow_dma_gnt    = w_dma_gnt;
   assign ow_core_stall = iw_core_req && !w_core_gnt && !iw_rst;

   // Memory command mux; addr/wdata hold their last issued value when idle.
   assign ow_mem_we    = (w_core_gnt && iw_core_we) || (w_dma_gnt && iw_dma_we);
   assign ow_mem_addr  = w_core_gnt ? iw_core_addr  : (w_dma_gnt ? iw_dma_addr  : r_addr);
   assign ow_mem_wdata = w_core_gnt ? iw_core_wdata : (w_dma_gnt ? iw_dma_wdata : r_wdata);

   assign ow_core_rvalid = r_rd_valid && (r_rd_owner == OWN_CORE);
   assign ow_dma_rvalid  = r_rd_valid && (r_rd_owner == OWN_DMA);
   assign ow_core_rdata  = ow_core_rvalid ? iw_mem_rdata : '0;
   assign ow_dma_rdata   = ow_dma_rvalid  ? iw_mem_rdata : '0;

   assign ow_dbg_state = r_state;

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         r_state    <= S_CORE;
         r_starve   <= '0;
         r_burst    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_owner <= OWN_CORE;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         if (w_core_gnt || w_dma_gnt) begin
            r_addr  <= ow_mem_addr;
            r_wdata <= ow_mem_wdata;
         end

         r_rd_valid <= (w_core_gnt && !iw_core_we) || (w_dma_gnt && !iw_dma_we);
         r_rd_owner <= w_dma_gnt ? OWN_DMA : OWN_CORE;

         if (iw_dma_req && !w_dma_gnt) begin
            if (r_starve != STARVE_LIM) r_starve <= r_starve + SW'(1);
         end else begin
            r_starve <= '0;
         end

         case (r_state)
            S_CORE: begin
               if (w_dma_gnt && iw_dma_lock) begin
                  // A one-grant burst is already complete on entry.
                  if (BURST_MAX == 1) begin
                     r_state <= S_YIELD;
                  end else begin
                     r_state <= S_BURST;
                     r_burst <= BW'(1);
                  end
               end
            end
            S_BURST: begin
               if (w_dma_gnt && ((r_burst + BW'(1)) != BURST_LIM)) begin
                  r_burst <= r_burst + BW'(1);
               end else begin
                  r_state <= S_YIELD;
                  r_burst <= '0;
               end
            end
            S_YIELD: r_state <= S_CORE;
            default: r_state <= S_CORE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arb.sv
module tb_dmem_arb;
   import dmem_arb_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic                 iw_clk = 1'b0;
   logic                 iw_rst;
   logic                 iw_core_req, iw_core_we;
   logic [HBIT_ADDR:0]   iw_core_addr;
   logic [HBIT_DATA:0]   iw_core_wdata;
   logic                 ow_core_gnt, ow_core_stall, ow_core_rvalid;
   logic [HBIT_DATA:0]   ow_core_rdata;
   logic                 iw_dma_req, iw_dma_we, iw_dma_lock;
   logic [HBIT_ADDR:0]   iw_dma_addr;
   logic [HBIT_DATA:0]   iw_dma_wdata;
   logic                 ow_dma_gnt, ow_dma_rvalid;
   logic [HBIT_DATA:0]   ow_dma_rdata;
   logic                 ow_mem_we;
   logic [HBIT_ADDR:0]   ow_mem_addr;
   logic [HBIT_DATA:0]   ow_mem_wdata;
   logic [HBIT_DATA:0]   iw_mem_rdata;
   logic [1:0]           ow_dbg_state;

   always #5 iw_clk = ~iw_clk;

   dmem_arb #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst),
      .iw_core_req(iw_core_req), .iw_core_we(iw_core_we),
      .iw_core_addr(iw_core_addr), .iw_core_wdata(iw_core_wdata),
      .ow_core_gnt(ow_core_gnt), .ow_core_stall(ow_core_stall),
      .ow_core_rvalid(ow_core_rvalid), .ow_core_rdata(ow_core_rdata),
      .iw_dma_req(iw_dma_req), .iw_dma_we(iw_dma_we),
      .iw_dma_addr(iw_dma_addr), .iw_dma_wdata(iw_dma_wdata),
      .iw_dma_lock(iw_dma_lock),
      .ow_dma_gnt(ow_dma_gnt), .ow_dma_rvalid(ow_dma_rvalid), .ow_dma_rdata(ow_dma_rdata),
      .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
      .iw_mem_rdata(iw_mem_rdata), .ow_dbg_state(ow_dbg_state)
   );

   // ---------------- memory environment (one-cycle read latency) ----------------
   logic [15:0] mem [256];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;

   always @(posedge iw_clk) begin
      if (ld_en)          mem[ld_addr] <= ld_data;
      else if (ow_mem_we) mem[ow_mem_addr[7:0]] <= ow_mem_wdata;
      iw_mem_rdata <= mem[ow_mem_addr[7:0]];
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; checks happen on the
   // falling edge, mid-cycle.
   task automatic tick();
      @(posedge iw_clk);
      #1;
   endtask

   task automatic settle();
      @(negedge iw_clk);
   endtask

   task automatic set_core(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      iw_core_req = req; iw_core_we = we; iw_core_addr = addr; iw_core_wdata = wdata;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic lock, input logic [15:0] addr, input logic [15:0] wdata);
      iw_dma_req = req; iw_dma_we = we; iw_dma_lock = lock; iw_dma_addr = addr; iw_dma_wdata = wdata;
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      ld_addr = a; ld_data = d; ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic exp_d, prev_d, g;
   int   k, c;

   initial begin
      iw_rst = 1'b1;
      set_core(1'b1, 1'b0, 16'h0010, 16'h0000);
      set_dma (1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
      preload(8'h10, 16'hABCD);
      preload(8'h20, 16'h1234);
      preload(8'h21, 16'h5678);
      preload(8'h30, 16'h9999);

      // Reset: requests present but nothing may be granted.
      settle();
      check("rst_core_gnt",  ow_core_gnt, 0);
      check("rst_dma_gnt",   ow_dma_gnt, 0);
      check("rst_stall",     ow_core_stall, 0);
      check("rst_mem_we",    ow_mem_we, 0);
      check("rst_mem_addr",  ow_mem_addr, 0);
      check("rst_rvalid",    {ow_core_rvalid, ow_dma_rvalid}, 0);
      check("rst_rdata",     {ow_core_rdata, ow_dma_rdata}, 0);
      check("rst_state",     ow_dbg_state, S_CORE);
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      set_dma (1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      iw_rst = 1'b0;

      // Single core read, DMA idle.
      set_core(1'b1, 1'b0, 16'h0010, 16'h0000);
      settle();
      check("rd_core_gnt",  ow_core_gnt, 1);
      check("rd_mem_addr",  ow_mem_addr, 16'h0010);
      check("rd_mem_we",    ow_mem_we, 0);
      tick();
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("rd_core_rvalid", ow_core_rvalid, 1);
      check("rd_core_rdata",  ow_core_rdata, 16'hABCD);
      check("rd_dma_rvalid",  ow_dma_rvalid, 0);
      check("rd_dma_rdata",   ow_dma_rdata, 0);

      // Idle bus.
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         check("idle_mem_we",  ow_mem_we, 0);
         check("idle_rvalid",  {ow_core_rvalid, ow_dma_rvalid}, 0);
         check("idle_gnt",     {ow_core_gnt, ow_dma_gnt}, 0);
         check("idle_addr_hold", ow_mem_addr, 16'h0010);
      end
      tick();

      // Both request every cycle, no lock: DMA wins every 5th cycle.
      set_core(1'b1, 1'b0, 16'h0020, 16'h0000);
      set_dma (1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
      prev_d = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         exp_d = ((i % 5) == 4);
         check("starve_dma_gnt",  ow_dma_gnt, exp_d);
         check("starve_core_gnt", ow_core_gnt, !exp_d);
         check("starve_stall",    ow_core_stall, exp_d);
         if (i > 0) begin
            check("starve_core_rdata", ow_core_rdata, prev_d ? 16'h0000 : 16'h1234);
            check("starve_dma_rdata",  ow_dma_rdata,  prev_d ? 16'h9999 : 16'h0000);
         end
         prev_d = exp_d;
         tick();
      end
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      set_dma (1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("starve_last_dma_rvalid", ow_dma_rvalid, 1);
      check("starve_last_dma_rdata",  ow_dma_rdata, 16'h9999);
      tick();

      // Locked 12-word DMA write burst against continuous core reads.
      set_core(1'b1, 1'b0, 16'h0020, 16'h0000);
      set_dma (1'b1, 1'b1, 1'b1, 16'h0040, 16'hD000);
      k = 0;
      c = 0;
      while (k < 12 && c < 40) begin
         settle();
         exp_d = (c >= 4 && c <= 11) || (c >= 16 && c <= 19);
         check("burst_dma_gnt",  ow_dma_gnt, exp_d);
         check("burst_core_gnt", ow_core_gnt, !exp_d);
         if (c == 4) begin
            check("burst_first_we",    ow_mem_we, 1);
            check("burst_first_wdata", ow_mem_wdata, 16'hD000);
         end
         if (c == 5)  check("burst_core_stall", ow_core_stall, 1);
         if (c == 6)  check("burst_state",      ow_dbg_state, S_BURST);
         if (c == 12) check("burst_yield",      ow_dbg_state, S_YIELD);
         if (c == 13) check("burst_back_core",  ow_dbg_state, S_CORE);
         g = ow_dma_gnt;
         tick();
         if (g) begin
            k++;
            iw_dma_addr  = 16'h0040 + 16'(k);
            iw_dma_wdata = 16'hD000 + 16'(k);
         end
         c++;
      end
      check("burst_len", c, 20);
      set_dma(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("burst_end_state", ow_dbg_state, S_BURST);
      check("burst_end_core",  ow_core_gnt, 1);
      tick();
      settle();
      check("burst_end_yield", ow_dbg_state, S_YIELD);
      tick();
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("burst_end_core_st", ow_dbg_state, S_CORE);
      tick();

      // Alternating core / DMA reads, back to back.
      set_core(1'b1, 1'b0, 16'h0010, 16'h0);
      settle();
      check("alt_c1_gnt", ow_core_gnt, 1);
      tick();
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      set_dma (1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
      settle();
      check("alt_d1_gnt",    ow_dma_gnt, 1);
      check("alt_c1_rvalid", {ow_core_rvalid, ow_dma_rvalid}, 2'b10);
      check("alt_c1_rdata",  ow_core_rdata, 16'hABCD);
      tick();
      set_dma (1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_core(1'b1, 1'b0, 16'h0021, 16'h0);
      settle();
      check("alt_c2_gnt",    ow_core_gnt, 1);
      check("alt_d1_rvalid", {ow_core_rvalid, ow_dma_rvalid}, 2'b01);
      check("alt_d1_rdata",  ow_dma_rdata, 16'hD000);
      check("alt_d1_crdata", ow_core_rdata, 0);
      tick();
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      set_dma (1'b1, 1'b0, 1'b0, 16'h004B, 16'h0);
      settle();
      check("alt_c2_rvalid", {ow_core_rvalid, ow_dma_rvalid}, 2'b10);
      check("alt_c2_rdata",  ow_core_rdata, 16'h5678);
      tick();
      set_dma(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("alt_d2_rvalid", {ow_core_rvalid, ow_dma_rvalid}, 2'b01);
      check("alt_d2_rdata",  ow_dma_rdata, 16'hD00B);
      tick();

      // Reset inside a locked DMA read burst with a read in flight.
      set_dma(1'b1, 1'b0, 1'b1, 16'h0041, 16'h0);
      settle();
      check("rb_gnt1", ow_dma_gnt, 1);
      tick();
      settle();
      check("rb_gnt2",  ow_dma_gnt, 1);
      check("rb_state", ow_dbg_state, S_BURST);
      tick();
      iw_rst = 1'b1;
      set_core(1'b1, 1'b0, 16'h0010, 16'h0);
      settle();
      check("rb_dma_rvalid", ow_dma_rvalid, 0);
      check("rb_dma_rdata",  ow_dma_rdata, 0);
      check("rb_core_gnt",   ow_core_gnt, 0);
      check("rb_state_rst",  ow_dbg_state, S_CORE);
      tick();
      iw_rst = 1'b0;
      settle();
      check("rb_post_core_gnt", ow_core_gnt, 1);
      check("rb_post_dma_gnt",  ow_dma_gnt, 0);
      tick();
      set_core(1'b0, 1'b0, 16'h0, 16'h0);
      set_dma (1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      settle();
      check("rb_post_rdata", ow_core_rdata, 16'hABCD);
      check("rb_post_state", ow_dbg_state, S_CORE);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
